// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM access controller.
// Grant encoding used by the round-robin arbiter's last-grant memory.
package spram_pkg;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/spram_access_ctrl.sv
// Arbitrates independent write and read requesters onto one external
// single-port synchronous RAM and returns read data through a one-entry
// response register with valid/ready flow control.
module spram_access_ctrl
    import spram_pkg::*;
#(
    parameter int MEM_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEM_WIDTH-1:0]  wr_data,

    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_WIDTH-1:0]  rsp_data,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0]  ram_din,
    input  logic [MEM_WIDTH-1:0]  ram_dout
);

    logic   pend;
    grant_e last_grant;
    logic   rd_elig;
    logic   contend;
    logic   grant_wr;
    logic   grant_rd;

    // A read may start only with nothing in flight and a response slot that
    // is empty or being emptied this cycle, so at most one read is outstanding.
    always_comb begin
        rd_elig = ~pend & (~rsp_valid | rsp_ready);
        contend = wr_valid & rd_valid & rd_elig;
    end

    // Grant selection: contention alternates using last_grant, otherwise the
    // single eligible requester wins; nothing is granted during reset.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst) begin
            if (contend) begin
                if (last_grant == GRANT_RD) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else if (wr_valid) begin
                grant_wr = 1'b1;
            end else if (rd_valid && rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;

    // RAM port drive: the granted request owns the RAM for this cycle; idle
    // cycles park address and data at zero.
    always_comb begin
        ram_we   = grant_wr;
        ram_addr = '0;
        ram_din  = '0;
        if (grant_wr) begin
            ram_addr = wr_addr;
            ram_din  = wr_data;
        end else if (grant_rd) begin
            ram_addr = rd_addr;
        end
    end

    // Fairness memory: only contended decisions are remembered, so an
    // uncontended write (e.g. during the pend cycle) does not steal the
    // read's next turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_RD;
        end else if (contend) begin
            last_grant <= grant_wr ? GRANT_WR : GRANT_RD;
        end
    end

    // Read pipeline: pend marks the cycle the RAM output register is being
    // loaded; the following edge captures ram_dout into the response slot,
    // so a write issued in the pend cycle cannot disturb the captured word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            pend <= grant_rd;
            if (pend) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ram_dout;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Scoreboard bench for spram_access_ctrl with a behavioural synchronous RAM.
module tb_spram_access_ctrl;

    localparam int MW = 24;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [MW-1:0] rsp_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_din;
    logic [MW-1:0] ram_dout;

    spram_access_ctrl #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, registered read-first output
    logic [MW-1:0] ram [256];
    logic [MW-1:0] ref_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [MW-1:0] data;
        int            acc_cyc;
    } exp_t;

    exp_t  exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    bit    holding = 0;
    bit    wr_acc = 0;
    bit    rd_acc = 0;
    bit    log_en = 0;
    string glog = "";

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: acceptance tracking, RAM-port checks and response scoreboard
    always @(negedge clk) begin
        wr_acc = 0;
        rd_acc = 0;
        if (rst) begin
            exp_q.delete();
            holding = 0;
            chk({wr_ready, rd_ready, ram_we} == 3'b000, "rst_quiet",
                {wr_ready, rd_ready, ram_we}, 0);
        end else begin
            chk(!(wr_ready && rd_ready), "ready_excl", {wr_ready, rd_ready}, 0);
            if (wr_ready) begin
                chk({ram_we, ram_addr, ram_din} == {1'b1, wr_addr, wr_data}, "ram_wr",
                    {ram_we, ram_addr, ram_din}, {1'b1, wr_addr, wr_data});
            end else if (rd_ready) begin
                chk({ram_we, ram_addr} == {1'b0, rd_addr}, "ram_rd",
                    {ram_we, ram_addr}, {1'b0, rd_addr});
            end else begin
                chk({ram_we, ram_addr, ram_din} == '0, "ram_idle",
                    {ram_we, ram_addr, ram_din}, 0);
            end
            if (log_en) glog = {glog, wr_ready ? "W" : (rd_ready ? "R" : "-")};
            if (wr_valid && wr_ready) begin
                ref_mem[wr_addr] = wr_data;
                wr_acc = 1;
            end
            if (rd_valid && rd_ready) begin
                exp_q.push_back('{data: ref_mem[rd_addr], acc_cyc: cyc});
                rd_acc = 1;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_rsp", rsp_data, 0);
                end else begin
                    if (!holding) begin
                        chk(cyc == exp_q[0].acc_cyc + 2, "rsp_latency",
                            cyc - exp_q[0].acc_cyc, 2);
                        holding = 1;
                    end
                    chk(rsp_data == exp_q[0].data, "rsp_data", rsp_data, exp_q[0].data);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        holding = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] d);
        bit done = 0;
        wr_valid = 1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = wr_ready;
            step();
        end
        wr_valid = 0;
        if (!done) chk(0, "wr_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit done = 0;
        rd_valid = 1; rd_addr = a;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = rd_ready;
            step();
        end
        rd_valid = 0;
        if (!done) chk(0, "rd_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) step();
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        rst = 1;
        repeat (2) step();
        rst = 0;
    endtask

    initial begin
        rst = 1; wr_valid = 1; rd_valid = 1; rsp_ready = 1;
        wr_addr = 8'h01; wr_data = 24'h111111; rd_addr = 8'h01;
        repeat (3) step();
        rst = 0; wr_valid = 0; rd_valid = 0;
        @(negedge clk);
        chk({rsp_valid, rsp_data} == '0, "reset_state", {rsp_valid, rsp_data}, 0);
        step();

        // Write then read back with latency check
        do_write(8'h05, 24'h00ABCD);
        do_read(8'h05);
        wait_rsp();

        // Contended grant pattern after reset
        apply_reset();
        wr_valid = 1; wr_addr = 8'h20; wr_data = 24'h5A5A5A;
        rd_valid = 1; rd_addr = 8'h20;
        glog = ""; log_en = 1;
        repeat (6) step();
        log_en = 0; wr_valid = 0; rd_valid = 0;
        n_chk++;
        if (glog == "WRWWRW") n_pass++;
        else $display("FAIL grant_seq: got %s required WRWWRW", glog);
        wait_rsp();

        // Backpressure on the response holds off further reads
        rsp_ready = 0;
        do_read(8'h05);
        for (int n = 0; n < 10 && !rsp_valid; n++) step();
        rd_valid = 1; rd_addr = 8'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(rd_ready == 0, "rd_blocked", rd_ready, 0);
            step();
        end
        rsp_ready = 1;
        @(negedge clk);
        chk(rd_ready == 1, "rd_release", rd_ready, 1);
        step();
        rd_valid = 0;
        wait_rsp();

        // Write in the pend cycle must not disturb the captured word
        do_write(8'h10, 24'h123456);
        do_read(8'h10);
        do_write(8'h10, 24'hFFFFFF);
        wait_rsp();
        do_read(8'h10);
        wait_rsp();

        // Reset while a read is outstanding
        do_read(8'h10);
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(rsp_valid == 0, "rsp_after_rst", rsp_valid, 0);
            step();
        end
        wr_valid = 1; wr_addr = 8'h30; wr_data = 24'hC0FFEE;
        rd_valid = 1; rd_addr = 8'h30;
        glog = ""; log_en = 1;
        repeat (2) step();
        log_en = 0; wr_valid = 0; rd_valid = 0;
        n_chk++;
        if (glog == "WR") n_pass++;
        else $display("FAIL post_rst_grant: got %s required WR", glog);
        wait_rsp();

        // Random traffic against the reference model
        for (int i = 0; i < 1000; i++) begin
            if (!wr_valid || wr_acc) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = 8'($urandom_range(0, 15));
                wr_data  = 24'($urandom);
            end
            if (!rd_valid || rd_acc) begin
                rd_valid = 1'($urandom_range(0, 1));
                rd_addr  = 8'($urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        if (wr_valid && !wr_acc) begin
            for (int n = 0; n < 50 && !wr_acc; n++) step();
        end
        wr_valid = 0;
        if (rd_valid && !rd_acc) begin
            for (int n = 0; n < 50 && !rd_acc; n++) step();
        end
        rd_valid = 0;
        rsp_ready = 1;
        wait_rsp();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spram_access_ctrl.md
SPRAM_ACCESS_CTRL -- requirements
Module: spram_access_ctrl

Interface
REQ-001 Parameter MEM_WIDTH, default 24, is the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, is the RAM address width in bits.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-high.
REQ-005 Port wr_valid  input  1  signals that a write request is offered.
REQ-006 Port wr_ready  output  1  signals that the write is accepted this cycle.
REQ-007 Port wr_addr  input  ADDR_WIDTH  is the write address.
REQ-008 Port wr_data  input  MEM_WIDTH  is the write data.
REQ-009 Port rd_valid  input  1  signals that a read request is offered.
REQ-010 Port rd_ready  output  1  signals that the read is accepted this cycle.
REQ-011 Port rd_addr  input  ADDR_WIDTH  is the read address.
REQ-012 Port rsp_valid  output  1  signals that read response data is valid.
REQ-013 Port rsp_ready  input  1  signals that the consumer accepts the response.
REQ-014 Port rsp_data  output  MEM_WIDTH  is the read response data.
REQ-015 Port ram_we  output  1  is the write enable to the external single-port synchronous RAM.
REQ-016 Port ram_addr  output  ADDR_WIDTH  is the RAM address.
REQ-017 Port ram_din  output  MEM_WIDTH  is the RAM write data.
REQ-018 Port ram_dout  input  MEM_WIDTH  is the RAM registered read data, valid one cycle after the address is presented.

Function
REQ-019 Handshakes complete on a cycle where valid and ready are both high; valid and payload are held by the sender until accepted.
REQ-020 At most one request (write or read) is issued to the RAM per cycle.
REQ-021 Read eligibility: pend==0 and (rsp_valid==0 or rsp_ready==1); at most one read is outstanding.
REQ-022 Arbitration: only one eligible requester -> grant it; both -> grant the one not granted last (last_grant); write granted whenever the read is ineligible.
REQ-023 wr_ready and rd_ready are combinational from the grant and never both high in the same cycle.
REQ-024 Write grant cycle: ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
REQ-025 Read grant cycle: ram_we=0, ram_addr=rd_addr; pend is set at the clock edge.
REQ-026 Idle cycle: ram_we=0, ram_addr and ram_din driven to 0.
REQ-027 When pend==1 at a clock edge: rsp_data<=ram_dout, rsp_valid<=1, pend<=0.
REQ-028 Read latency: read accepted in cycle N -> rsp_valid high from cycle N+2.
REQ-029 A write issued in the pend cycle does not corrupt the captured read data.
REQ-030 rsp_valid clears on an rsp_ready handshake unless a new capture occurs at the same edge.
REQ-031 rsp_data is stable while rsp_valid==1 and rsp_ready==0.
REQ-032 Ordering: requests take effect in grant order; a read granted after a write to the same address returns the new data.
REQ-033 Peak throughput: one write per cycle with no reads; reads at one per two cycles when rsp_ready is held high.

Reset
REQ-034 rst==1 at a clock edge sets pend=0, rsp_valid=0, rsp_data=0 and last_grant=read, so the first contended grant goes to the write.
REQ-035 While rst==1, wr_ready=0, rd_ready=0 and ram_we=0.
REQ-036 Reset during an outstanding read discards that read; no response is produced for it.

Structure
REQ-037 A shared package spram_pkg holds the grant encoding constants (GRANT_WR, GRANT_RD); the width parameters stay module parameters.
REQ-038 Single flat module, no sub-modules; the RAM is external and connected through the ram_* ports.

Verification
REQ-039 Write 0x00ABCD to addr 0x05, then read 0x05 -> rsp_valid high 2 cycles after read accept, rsp_data=0x00ABCD.
REQ-040 wr_valid and rd_valid held high together for 6 cycles after reset -> grants alternate W,R,W,W,R,W (read ineligible on the cycle after its grant).
REQ-041 rsp_ready=0 for 5 cycles with a response pending -> rd_ready=0 throughout, rsp_data held; release -> next read is accepted in the same cycle.
REQ-042 Read addr 0x10, then write 0xFFFFFF to 0x10 in the pend cycle -> rsp_data equals the old contents of 0x10.
REQ-043 Assert rst the cycle after a read is accepted -> rsp_valid never rises; first post-reset contended grant is the write.
REQ-044 1000 random valid/ready cycles checked against a reference memory model -> every response matches, with no lost or duplicated requests.
